// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the core fetch stage.
// Holds the loader state encoding and the instruction word constants.
package imem_loader_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Source word stream plus instruction-memory write port seen by the loader.
// slave = loader side, master = source / memory side.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = INST_W,
    parameter int ADDR_W = 16
);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_loader.sv
// Loads an instruction image into imem from address 0, optionally NOP-fills the rest, then releases the core.
// Write port is registered: one cycle from accepted word to mem_we; in_ready is high only in LOAD.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_W  = INST_W,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 65536,
    parameter bit FILL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    imem_loader_if.slave    bus,
    output logic            core_rst,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic [ADDR_W:0] word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              final_wr;
    logic              xfer;

    // final_wr holds the FSM one cycle so the last write never overlaps core release.
    assign bus.in_ready = (state == LOAD) && !final_wr;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign busy         = (state == LOAD) || (state == FILL);
    assign done         = (state == DONE);
    assign core_rst     = (state != DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            addr          <= '0;
            final_wr      <= 1'b0;
            word_count    <= '0;
            overflow      <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        addr       <= '0;
                        final_wr   <= 1'b0;
                        word_count <= '0;
                        overflow   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (final_wr) begin
                        state <= DONE;
                    end else if (xfer) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= addr;
                        bus.mem_wdata <= bus.in_data;
                        word_count    <= word_count + 1'b1;
                        if (addr == LAST_ADDR) begin
                            final_wr <= 1'b1;
                            overflow <= !bus.in_last;
                        end else begin
                            addr <= addr + 1'b1;
                            if (bus.in_last) begin
                                if (FILL_EN) state <= FILL;
                                else         final_wr <= 1'b1;
                            end
                        end
                    end
                end
                FILL: begin
                    if (final_wr) begin
                        state <= DONE;
                    end else begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= addr;
                        bus.mem_wdata <= DATA_W'(NOP_WORD);
                        if (addr == LAST_ADDR) final_wr <= 1'b1;
                        else                   addr     <= addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into instruction memory from address 0 upward.
- Optionally zero-fills (NOP) the remaining words.
- Holds the pipelined core in reset until the image is complete, then releases it.
- Sits between the program source (bench or debug port) and the instruction memory write port, alongside the core's fetch stage.

Parameters:
- DATA_W, 32, instruction word width
- ADDR_W, 16, instruction memory word-address width
- DEPTH, 65536, number of words in instruction memory (≤ 2**ADDR_W)
- FILL_EN, 1, 1 = write zero (NOP) to every address after the last loaded word

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a load (one-cycle pulse)
- in_valid  in  1  source word valid
- in_data  in  DATA_W  instruction word
- in_last  in  1  marks final word of the image
- in_ready  out  1  loader accepts a word this cycle
- mem_we  out  1  instruction memory write enable
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  DATA_W  write data
- core_rst  out  1  active-high reset to core; 1 while loading
- busy  out  1  state is LOAD or FILL
- done  out  1  image complete, core released
- overflow  out  1  sticky; image exceeded DEPTH without in_last
- word_count  out  ADDR_W+1  words accepted in the current load

Behaviour:
- Reset (rst=0, asynchronous) values:
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
  - core_rst=1, busy=0, done=0, overflow=0, word_count=0
  - state=IDLE, internal addr=0
- FSM states: IDLE, LOAD, FILL, DONE.
- IDLE:
  - core_rst=1, in_ready=0.
  - start -> LOAD; addr=0, word_count=0, overflow=0.
- LOAD:
  - in_ready=1 combinationally from state.
  - Transfer occurs on in_valid & in_ready.
  - Each transfer registers the write; next cycle mem_we=1, mem_addr=addr, mem_wdata=in_data (1-cycle latency).
  - On each transfer: addr+1, word_count+1.
  - mem_we=0 in cycles with no transfer; in_valid without ready has no effect.
  - Transfer with in_last=1:
    - -> FILL if FILL_EN and addr<DEPTH-1, else -> DONE.
  - Transfer at addr=DEPTH-1 with in_last=0:
    - overflow=1 (sticky until next start), word written, -> DONE.
    - Later source words are not accepted.
  - start ignored.
- FILL:
  - in_ready=0.
  - One write per cycle of mem_wdata=0 to addresses addr .. DEPTH-1, ascending, mem_we=1 each cycle.
  - After the write to DEPTH-1 -> DONE.
  - word_count unchanged.
  - start ignored.
- DONE:
  - Entered the cycle after the final write is presented; core_rst=0 and done=1 from that cycle.
  - The last write's mem_we is therefore never concurrent with core release.
  - in_ready=0, mem_we=0.
  - start -> LOAD: core_rst=1 and done=0 in the same edge; addr, word_count and overflow cleared.
- busy=1 exactly in LOAD and FILL.
- Boundary rules:
  - start and a transfer in the same cycle of LOAD: the transfer is processed, start is ignored.
  - in_last on the word at DEPTH-1: no overflow; -> DONE, no FILL.
  - Single-word image (first word has in_last): write addr 0, then fill 1..DEPTH-1.
  - Reset mid-LOAD/FILL: outputs return to reset values immediately; partial image not resumed.
- Width rules:
  - addr is ADDR_W bits; DEPTH-1 compare is exact; no wrap past DEPTH-1 is ever generated.
  - word_count is ADDR_W+1 bits so it can hold DEPTH.

Decomposition:
- Shared package holds:
  - state enum (IDLE, LOAD, FILL, DONE)
  - NOP_WORD constant (32'h0000_0000)
  - INST_W=32 constant, also used by the core's fetch stage
- Single module; no sub-module needed.
- The write-port register stage is inline (mem_we/mem_addr/mem_wdata flops).

Test Plan:
- DEPTH=32, FILL_EN=1: reset, start, stream 5 words (0x00221820, 0x00221820, 0x00201820, 0, 0x10230003, last on 5th), valid always high -> writes at addr 0..4 one per cycle with 1-cycle latency; zero writes at 5..31; done=1 and core_rst=0 the cycle after addr 31 write; word_count=5; overflow=0.
- DEPTH=32, FILL_EN=1, valid toggled every other cycle -> mem_we only the cycle after each accepted word; addresses contiguous 0..N-1, no duplicate or skipped writes.
- DEPTH=8, FILL_EN=1, stream 10 words without in_last -> 8 writes (0..7); overflow=1; in_ready=0 after the 8th; done=1, core_rst=0; word_count=8.
- DEPTH=8, FILL_EN=0, 3 words with last -> writes 0..2 only; DONE immediately after; no zero writes.
- Assert rst=0 during FILL at addr 12 (DEPTH=32) -> asynchronously mem_we=0, core_rst=1, busy=0, done=0; restart with start -> load begins at addr 0, overflow and word_count cleared.
- In DONE, pulse start -> core_rst=1 and done=0 next edge; second image overwrites from addr 0; start pulses during LOAD/FILL ignored.
